itlb_refill_ctrl: RTL and testbench
===================================

# itlb_refill_ctrl

Miss-handling and refill controller for the instruction TLB. It watches per-entry hit/valid vectors from the ITLB tag array and detects misses. On a miss it requests a translation from the page-table walker over a valid/ready handshake, picks a victim entry and pulses that entry's write enable with the captured ASID/VPN/global bit. It also sequences `sfence`-driven flushes against in-flight walks, so no stale refill lands after a flush.

## Interface
Parameters:
- `ENTRIES`, 8: number of ITLB entries; power of two, at least 2.
- `ASID_WD`, 9: ASID width.
- `VPN_WD`, 20: VPN width (vpn1 and vpn0, 10 bits each).

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset; synchronous and active-high.
- `lookup_valid_i`, in, 1: fetch translation lookup this cycle.
- `lookup_asid_i`, in, `ASID_WD`: lookup ASID.
- `lookup_vpn_i`, in, `VPN_WD`: lookup VPN.
- `hit_vec_i`, in, `ENTRIES`: per-entry hit from tag array (combinational, same cycle).
- `valid_vec_i`, in, `ENTRIES`: per-entry valid state.
- `tlb_flush_i`, in, 1: flush request, single-cycle pulse.
- `ptw_req_valid_o`, out, 1: walk request valid.
- `ptw_req_ready_i`, in, 1: PTW accepts the request.
- `ptw_req_asid_o`, out, `ASID_WD`: captured miss ASID.
- `ptw_req_vpn_o`, out, `VPN_WD`: captured miss VPN.
- `ptw_resp_valid_i`, in, 1: walk result valid, single-cycle pulse.
- `ptw_resp_g_i`, in, 1: PTE global bit.
- `ptw_resp_fault_i`, in, 1: walk faulted.
- `entry_we_o`, out, `ENTRIES`: one-hot entry write enable.
- `entry_asid_o`, out, `ASID_WD`: refill ASID.
- `entry_vpn_o`, out, `VPN_WD`: refill VPN.
- `entry_g_o`, out, 1: refill global bit.
- `flush_o`, out, 1: flush broadcast to all entries.
- `stall_o`, out, 1: fetch must hold the lookup.
- `fault_o`, out, 1: one-cycle page-fault pulse to fetch.

## Operation
- FSM states: IDLE, REQ, WAIT, FILL, DRAIN. The reset state is IDLE.
- Miss condition: `lookup_valid_i & ~|hit_vec_i` while in IDLE and `tlb_flush_i` low.
  - On a miss, capture the ASID and VPN into `ptw_req_*_o` and go to REQ.
- REQ:
  - Hold `ptw_req_valid_o` high with stable payload until `ptw_req_ready_i`, then go to WAIT.
- WAIT: hold until `ptw_resp_valid_i`.
  - If `ptw_resp_fault_i` is set: pulse `fault_o` and go to IDLE with no write.
  - Otherwise: register `ptw_resp_g_i` and go to FILL.
- FILL, one cycle:
  - Drive `entry_we_o` one-hot at the victim, with `entry_*_o` equal to the captured values.
  - Go to IDLE.
- Victim selection:
  - Pick the lowest-index entry with `valid_vec_i` low.
  - If all entries are valid, use the round-robin pointer `rr_q`.
  - `rr_q` advances by one, modulo `ENTRIES` with natural wrap, only when a full-array fill uses it.
- `stall_o` = (state != IDLE) | miss condition.
- Flush handling. `flush_o` = `tlb_flush_i`, combinational, in every state. On flush, `rr_q` resets to 0, and the state responds as follows:
  - IDLE: stay; no miss is taken that cycle.
  - REQ without handshake that cycle: drop the request and go to IDLE.
  - REQ with handshake that cycle, or WAIT without `ptw_resp_valid_i`: go to DRAIN.
  - WAIT with `ptw_resp_valid_i` that same cycle: go to IDLE, no fill, no fault.
  - FILL: suppress `entry_we_o` and go to IDLE.
- DRAIN:
  - `ptw_req_valid_o` low and `stall_o` high.
  - On `ptw_resp_valid_i`, discard the result (no fill, no fault) and go to IDLE.
  - A flush in DRAIN keeps the controller in DRAIN.
- `entry_we_o` and `flush_o` are never both high in the same cycle.

## Timing
- Reset values: state IDLE, `rr_q` = 0, all outputs 0, captured registers 0.
- Miss seen in cycle T → `ptw_req_valid_o` high at T+1.
- With ready at T+1 and a response at T+k (k ≥ 2): `entry_we_o` is at T+k+1 and the stall ends at T+k+2.
  - Minimum miss penalty is 4 cycles (T to T+3 stalled).
- `fault_o` is high in the cycle after the faulting response.
- Hits in IDLE add no stall.
- `rst_i` asserted mid-walk returns to IDLE next edge. Any later PTW response is ignored while IDLE.

## Configuration
- `ITLB_PERF_CNT_EN` defined:
  - Adds two 32-bit outputs, `hit_cnt_o` and `miss_cnt_o`, both resetting to 0.
  - `hit_cnt_o` increments on IDLE lookups with any hit; `miss_cnt_o` increments on each miss capture.
  - Both saturate at `32'hFFFF_FFFF`. Neither is cleared by flush.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- `mms_pkg` holds:
  - the FSM state enum `itlb_refill_state_e`;
  - the `vpn_t`/ASID width defines reused from the tag array;
  - the PTW request and response structs.
- One sub-module, `itlb_victim_sel`: combinational first-invalid priority encoder plus round-robin fallback, producing a one-hot victim.

## Test plan
- Cold miss, `valid_vec_i=0`, VPN `0x4_01FF`, ASID 2:
  - ready at T+1, response at T+3 with g=0;
  - expect `entry_we_o=8'h01` at T+4 with VPN `0x4_01FF`, ASID 2, and `stall_o` low at T+5.
- All entries valid, 9 successive misses:
  - `entry_we_o` walks `01,02,…,80`, then wraps back to `01`.
- Faulting walk:
  - expect one `fault_o` pulse, `entry_we_o` stays 0, return to IDLE.
- Flush while in WAIT, response 3 cycles later:
  - `flush_o` pulses, state goes to DRAIN, the response is discarded, no write, `rr_q`=0.
- Flush in the FILL cycle:
  - `entry_we_o` stays 0 and `flush_o` is 1.
- `ITLB_PERF_CNT_EN` build, 5 hits and 2 misses:
  - expect `hit_cnt_o`=5 and `miss_cnt_o`=2.

Source files
------------

// File: rtl/itlb_refill_ctrl_pkg.sv
// rtl/itlb_refill_ctrl_pkg.sv - shared types and widths for the ITLB refill controller
package mms_pkg;

    localparam int ITLB_ASID_WD = 9;
    localparam int ITLB_VPN_WD  = 20;

    typedef logic [ITLB_VPN_WD-1:0]  vpn_t;
    typedef logic [ITLB_ASID_WD-1:0] asid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL,
        ST_DRAIN
    } itlb_refill_state_e;

    typedef struct packed {
        asid_t asid;
        vpn_t  vpn;
    } ptw_req_t;

    typedef struct packed {
        logic g;
        logic fault;
    } ptw_resp_t;

endpackage

// File: rtl/itlb_refill_ctrl_if.sv
// rtl/itlb_refill_ctrl_if.sv - page-table walker request/response bundle
interface itlb_refill_ctrl_if
    import mms_pkg::*;
#(
    parameter int ASID_WD = ITLB_ASID_WD,
    parameter int VPN_WD  = ITLB_VPN_WD
);
    logic               ptw_req_valid_o;
    logic               ptw_req_ready_i;
    logic [ASID_WD-1:0] ptw_req_asid_o;
    logic [VPN_WD-1:0]  ptw_req_vpn_o;
    logic               ptw_resp_valid_i;
    logic               ptw_resp_g_i;
    logic               ptw_resp_fault_i;

    modport master (
        output ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o,
        input  ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_g_i, ptw_resp_fault_i
    );

    modport slave (
        input  ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o,
        output ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_g_i, ptw_resp_fault_i
    );
endinterface

// File: rtl/itlb_refill_ctrl_victim_sel.sv
// rtl/itlb_refill_ctrl_victim_sel.sv - first-invalid victim picker with round-robin fallback
module itlb_victim_sel #(
    parameter int ENTRIES = 8,
    localparam int RR_WD  = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] valid_vec,
    input  logic [RR_WD-1:0]   rr,
    output logic [ENTRIES-1:0] victim,
    output logic               all_valid
);
    logic found;

    // Lowest free slot wins; only a completely full array falls back to rr.
    always_comb begin
        victim    = '0;
        found     = 1'b0;
        all_valid = &valid_vec;
        if (all_valid) begin
            victim[rr] = 1'b1;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (!valid_vec[i] && !found) begin
                    victim[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/itlb_refill_ctrl.sv
// rtl/itlb_refill_ctrl.sv - ITLB miss/refill/flush sequencer; optional ITLB_PERF_CNT_EN hit/miss counters
module itlb_refill_ctrl
    import mms_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int ASID_WD = ITLB_ASID_WD,
    parameter int VPN_WD  = ITLB_VPN_WD,
    localparam int RR_WD  = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               lookup_valid_i,
    input  logic [ASID_WD-1:0] lookup_asid_i,
    input  logic [VPN_WD-1:0]  lookup_vpn_i,
    input  logic [ENTRIES-1:0] hit_vec_i,
    input  logic [ENTRIES-1:0] valid_vec_i,
    input  logic               tlb_flush_i,
    itlb_refill_ctrl_if.master ptw,
    output logic [ENTRIES-1:0] entry_we_o,
    output logic [ASID_WD-1:0] entry_asid_o,
    output logic [VPN_WD-1:0]  entry_vpn_o,
    output logic               entry_g_o,
    output logic               flush_o,
    output logic               stall_o,
`ifdef ITLB_PERF_CNT_EN
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o,
`endif
    output logic               fault_o
);
    itlb_refill_state_e state_q, state_d;
    logic [ASID_WD-1:0] asid_q;
    logic [VPN_WD-1:0]  vpn_q;
    logic               g_q;
    logic               fault_q;
    logic [RR_WD-1:0]   rr_q;
    logic [ENTRIES-1:0] victim;
    logic               all_valid;
    logic               miss;
    logic               resp_ok;

    assign miss    = (state_q == ST_IDLE) && lookup_valid_i && !(|hit_vec_i) && !tlb_flush_i;
    assign resp_ok = (state_q == ST_WAIT) && ptw.ptw_resp_valid_i && !tlb_flush_i;

    assign ptw.ptw_req_valid_o = (state_q == ST_REQ);
    assign ptw.ptw_req_asid_o  = asid_q;
    assign ptw.ptw_req_vpn_o   = vpn_q;
    assign entry_asid_o        = asid_q;
    assign entry_vpn_o         = vpn_q;
    assign entry_g_o           = g_q;
    assign flush_o             = tlb_flush_i;
    assign fault_o             = fault_q;

    itlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
        .valid_vec (valid_vec_i),
        .rr        (rr_q),
        .victim    (victim),
        .all_valid (all_valid)
    );

    // Next state plus write-enable/stall; a flush aborts or drains any walk in flight.
    always_comb begin
        state_d    = state_q;
        entry_we_o = '0;
        stall_o    = (state_q != ST_IDLE) || miss;
        unique case (state_q)
            ST_IDLE:  if (miss) state_d = ST_REQ;
            ST_REQ: begin
                if (tlb_flush_i)                 state_d = ptw.ptw_req_ready_i ? ST_DRAIN : ST_IDLE;
                else if (ptw.ptw_req_ready_i)    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ptw.ptw_resp_valid_i)        state_d = (tlb_flush_i || ptw.ptw_resp_fault_i) ? ST_IDLE : ST_FILL;
                else if (tlb_flush_i)            state_d = ST_DRAIN;
            end
            ST_FILL: begin
                if (!tlb_flush_i) entry_we_o = victim;
                state_d = ST_IDLE;
            end
            ST_DRAIN: if (ptw.ptw_resp_valid_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, captured miss payload, fault pulse and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            asid_q  <= '0;
            vpn_q   <= '0;
            g_q     <= 1'b0;
            fault_q <= 1'b0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= resp_ok && ptw.ptw_resp_fault_i;
            if (miss) begin
                asid_q <= lookup_asid_i;
                vpn_q  <= lookup_vpn_i;
            end
            if (resp_ok && !ptw.ptw_resp_fault_i) g_q <= ptw.ptw_resp_g_i;
            if (tlb_flush_i)                            rr_q <= '0;
            else if (state_q == ST_FILL && all_valid)   rr_q <= rr_q + RR_WD'(1);
        end
    end

`ifdef ITLB_PERF_CNT_EN
    // Saturating lookup statistics; flushes leave them alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (state_q == ST_IDLE && lookup_valid_i && (|hit_vec_i) && hit_cnt_o != 32'hFFFF_FFFF)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss && miss_cnt_o != 32'hFFFF_FFFF)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// tb/tb_itlb_refill_ctrl.sv - self-checking bench for itlb_refill_ctrl
module tb_itlb_refill_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_valid, tlb_flush;
    logic [8:0]  lookup_asid;
    logic [19:0] lookup_vpn;
    logic [7:0]  hit_vec, valid_vec;
    logic [7:0]  entry_we;
    logic [8:0]  entry_asid;
    logic [19:0] entry_vpn;
    logic        entry_g, flush_o, stall, fault;
`ifdef ITLB_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    typedef struct {
        logic [7:0]  we;
        logic [8:0]  asid;
        logic [19:0] vpn;
        logic        g;
    } exp_t;
    exp_t sb[$];
    exp_t got;

    typedef struct {
        logic [7:0]  vv;
        logic [8:0]  asid;
        logic [19:0] vpn;
        logic        g;
        logic [7:0]  exp_we;
    } vec_t;
    vec_t tbl[14];

    always #5 clk = ~clk;

    itlb_refill_ctrl_if #(.ASID_WD(9), .VPN_WD(20)) ptw_if ();

    itlb_refill_ctrl #(.ENTRIES(8), .ASID_WD(9), .VPN_WD(20)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .lookup_valid_i (lookup_valid),
        .lookup_asid_i  (lookup_asid),
        .lookup_vpn_i   (lookup_vpn),
        .hit_vec_i      (hit_vec),
        .valid_vec_i    (valid_vec),
        .tlb_flush_i    (tlb_flush),
        .ptw            (ptw_if),
        .entry_we_o     (entry_we),
        .entry_asid_o   (entry_asid),
        .entry_vpn_o    (entry_vpn),
        .entry_g_o      (entry_g),
        .flush_o        (flush_o),
        .stall_o        (stall),
`ifdef ITLB_PERF_CNT_EN
        .hit_cnt_o      (hit_cnt),
        .miss_cnt_o     (miss_cnt),
`endif
        .fault_o        (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write that appears must match the oldest expected refill.
    always @(negedge clk) begin
        if (entry_we !== 8'h00) begin
            check("we_flush_exclusive", {31'd0, flush_o}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_write", {24'd0, entry_we}, 32'd0);
            end else begin
                got = sb.pop_front();
                check("sb_we",   {24'd0, entry_we},   {24'd0, got.we});
                check("sb_asid", {23'd0, entry_asid}, {23'd0, got.asid});
                check("sb_vpn",  {12'd0, entry_vpn},  {12'd0, got.vpn});
                check("sb_g",    {31'd0, entry_g},    {31'd0, got.g});
            end
        end
    end

    task automatic miss_walk(input logic [7:0] vv, input logic [8:0] asid, input logic [19:0] vpn,
                             input logic g, input logic flt, input logic flush_fill, input logic [7:0] exp_we);
        step();
        lookup_valid = 1'b1; hit_vec = 8'h00; valid_vec = vv;
        lookup_asid = asid; lookup_vpn = vpn;
        exp_miss++;
        if (!flt && !flush_fill) sb.push_back('{exp_we, asid, vpn, g});
        @(negedge clk);
        check("miss_stall", {31'd0, stall}, 32'd1);
        check("miss_req_low", {31'd0, ptw_if.ptw_req_valid_o}, 32'd0);
        step();
        lookup_valid = 1'b0; ptw_if.ptw_req_ready_i = 1'b1;
        @(negedge clk);
        check("req_valid", {31'd0, ptw_if.ptw_req_valid_o}, 32'd1);
        check("req_asid", {23'd0, ptw_if.ptw_req_asid_o}, {23'd0, asid});
        check("req_vpn", {12'd0, ptw_if.ptw_req_vpn_o}, {12'd0, vpn});
        step();
        ptw_if.ptw_req_ready_i = 1'b0;
        @(negedge clk);
        check("wait_req_low", {31'd0, ptw_if.ptw_req_valid_o}, 32'd0);
        check("wait_stall", {31'd0, stall}, 32'd1);
        step();
        ptw_if.ptw_resp_valid_i = 1'b1; ptw_if.ptw_resp_g_i = g; ptw_if.ptw_resp_fault_i = flt;
        @(negedge clk);
        step();
        ptw_if.ptw_resp_valid_i = 1'b0; ptw_if.ptw_resp_fault_i = 1'b0; tlb_flush = flush_fill;
        @(negedge clk);
        check("fault_pulse", {31'd0, fault}, {31'd0, flt});
        check("fill_stall", {31'd0, stall}, {31'd0, !flt});
        if (flush_fill) begin
            check("fill_flush_o", {31'd0, flush_o}, 32'd1);
            check("fill_flush_we", {24'd0, entry_we}, 32'd0);
        end else if (!flt) begin
            check("fill_we_timing", {24'd0, entry_we}, {24'd0, exp_we});
        end
        step();
        tlb_flush = 1'b0;
        @(negedge clk);
        check("post_stall", {31'd0, stall}, 32'd0);
        check("post_fault", {31'd0, fault}, 32'd0);
        check("post_we", {24'd0, entry_we}, 32'd0);
    endtask

    initial begin
        lookup_valid = 1'b0; tlb_flush = 1'b0; lookup_asid = '0; lookup_vpn = '0;
        hit_vec = '0; valid_vec = '0;
        ptw_if.ptw_req_ready_i = 1'b0; ptw_if.ptw_resp_valid_i = 1'b0;
        ptw_if.ptw_resp_g_i = 1'b0; ptw_if.ptw_resp_fault_i = 1'b0;

        tbl[0] = '{8'h00, 9'd2,  20'h401FF, 1'b0, 8'h01};
        tbl[1] = '{8'h07, 9'd7,  20'h00123, 1'b1, 8'h08};
        tbl[2] = '{8'h7F, 9'd1,  20'hFFFFF, 1'b0, 8'h80};
        tbl[3] = '{8'hFE, 9'd511, 20'h0A5A5, 1'b1, 8'h01};
        tbl[4] = '{8'hB5, 9'd9,  20'h12345, 1'b0, 8'h02};
        for (int i = 0; i < 9; i++)
            tbl[5+i] = '{8'hFF, 9'(i + 16), 20'(32'h1000 + i), i[0], 8'h01 << (i % 8)};

        repeat (2) step();
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req_valid", {31'd0, ptw_if.ptw_req_valid_o}, 32'd0);
        check("rst_we", {24'd0, entry_we}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_req_vpn", {12'd0, ptw_if.ptw_req_vpn_o}, 32'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            miss_walk(tbl[i].vv, tbl[i].asid, tbl[i].vpn, tbl[i].g, 1'b0, 1'b0, tbl[i].exp_we);

        miss_walk(8'h00, 9'd5, 20'h54321, 1'b1, 1'b1, 1'b0, 8'h00);

        // Flush while waiting on the walker; the late response must be dropped.
        step();
        lookup_valid = 1'b1; hit_vec = 8'h00; valid_vec = 8'hFF; lookup_asid = 9'd3; lookup_vpn = 20'h00ABC;
        exp_miss++;
        step();
        lookup_valid = 1'b0; ptw_if.ptw_req_ready_i = 1'b1;
        step();
        ptw_if.ptw_req_ready_i = 1'b0; tlb_flush = 1'b1;
        @(negedge clk);
        check("wflush_flush_o", {31'd0, flush_o}, 32'd1);
        check("wflush_stall", {31'd0, stall}, 32'd1);
        step();
        tlb_flush = 1'b0;
        @(negedge clk);
        check("drain_req_low", {31'd0, ptw_if.ptw_req_valid_o}, 32'd0);
        check("drain_stall", {31'd0, stall}, 32'd1);
        step();
        @(negedge clk);
        check("drain_stall2", {31'd0, stall}, 32'd1);
        step();
        ptw_if.ptw_resp_valid_i = 1'b1;
        @(negedge clk);
        check("drain_resp_stall", {31'd0, stall}, 32'd1);
        step();
        ptw_if.ptw_resp_valid_i = 1'b0;
        @(negedge clk);
        check("drain_done_stall", {31'd0, stall}, 32'd0);
        check("drain_no_fault", {31'd0, fault}, 32'd0);
        check("drain_no_we", {24'd0, entry_we}, 32'd0);

        // rr was 1 before the flush; after it the full-array fill must land on entry 0.
        miss_walk(8'hFF, 9'd4, 20'h0BEEF, 1'b0, 1'b0, 1'b0, 8'h01);
        miss_walk(8'hFF, 9'd6, 20'h0CAFE, 1'b1, 1'b0, 1'b1, 8'h00);
        miss_walk(8'hFF, 9'd8, 20'h0D00D, 1'b1, 1'b0, 1'b0, 8'h01);

        // Flush while requesting without a handshake drops the walk.
        step();
        lookup_valid = 1'b1; hit_vec = 8'h00; lookup_asid = 9'd10; lookup_vpn = 20'h00010;
        exp_miss++;
        step();
        lookup_valid = 1'b0; tlb_flush = 1'b1;
        @(negedge clk);
        check("rflush_req_valid", {31'd0, ptw_if.ptw_req_valid_o}, 32'd1);
        step();
        tlb_flush = 1'b0;
        @(negedge clk);
        check("rflush_idle_stall", {31'd0, stall}, 32'd0);
        check("rflush_req_low", {31'd0, ptw_if.ptw_req_valid_o}, 32'd0);

        // A miss coinciding with a flush in IDLE is not taken.
        step();
        lookup_valid = 1'b1; hit_vec = 8'h00; tlb_flush = 1'b1;
        @(negedge clk);
        check("iflush_stall", {31'd0, stall}, 32'd0);
        step();
        lookup_valid = 1'b0; tlb_flush = 1'b0;
        @(negedge clk);
        check("iflush_req_low", {31'd0, ptw_if.ptw_req_valid_o}, 32'd0);

        // Reset mid-walk, then a stray response must be ignored.
        step();
        lookup_valid = 1'b1; hit_vec = 8'h00; lookup_asid = 9'd12; lookup_vpn = 20'h00777;
        step();
        lookup_valid = 1'b0; ptw_if.ptw_req_ready_i = 1'b1;
        step();
        ptw_if.ptw_req_ready_i = 1'b0; rst = 1'b1;
        exp_hits = 0; exp_miss = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_stall", {31'd0, stall}, 32'd0);
        check("mrst_req_asid", {23'd0, ptw_if.ptw_req_asid_o}, 32'd0);
        step();
        ptw_if.ptw_resp_valid_i = 1'b1; ptw_if.ptw_resp_fault_i = 1'b1;
        step();
        ptw_if.ptw_resp_valid_i = 1'b0; ptw_if.ptw_resp_fault_i = 1'b0;
        @(negedge clk);
        check("mrst_no_fault", {31'd0, fault}, 32'd0);
        check("mrst_idle", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            step();
            lookup_valid = 1'b1; hit_vec = 8'h10 >> (i % 4);
            exp_hits++;
            @(negedge clk);
            check("hit_no_stall", {31'd0, stall}, 32'd0);
        end
        step();
        lookup_valid = 1'b0; hit_vec = 8'h00;
        miss_walk(8'h00, 9'd2, 20'h401FF, 1'b0, 1'b0, 1'b0, 8'h01);
        miss_walk(8'h03, 9'd3, 20'h00042, 1'b1, 1'b0, 1'b0, 8'h04);

`ifdef ITLB_PERF_CNT_EN
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_miss);
`endif
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
